// File: rtl/hex_led_pio_ctrl.sv
// rtl/hex_led_pio_ctrl.sv - Avalon-MM seven-segment and LED controller with blink and PWM dimming
module hex_led_pio_ctrl #(
  parameter int NUM_DIGITS     = 6,
  parameter int LED_WIDTH      = 10,
  parameter int CLK_HZ         = 50000000,
  parameter int BLINK_HZ       = 2,
  parameter int PWM_BITS       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [3:0]              avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  output logic [LED_WIDTH-1:0]    led_export,
  output logic [NUM_DIGITS*8-1:0] hex_export,
  output logic                    blink_phase
);

  localparam int BLINK_DIV_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_DIV     = (BLINK_DIV_RAW < 1) ? 1 : BLINK_DIV_RAW;
  localparam int PRE_W         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);
  localparam logic [NUM_DIGITS*8-1:0] HEX_BLANK = SEG_ACTIVE_LOW ? '1 : '0;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // decode -> blink blank -> PWM blank -> pin polarity
  function automatic logic [7:0] digit_pins(input logic raw, input logic [7:0] d,
                                            input logic blink_off, input logic pwm_on);
    logic [7:0] g;
    g = {d[7], raw ? d[6:0] : hex_glyph(d[3:0])};
    if (blink_off) g = 8'h00;
    if (!pwm_on)   g = 8'h00;
    return SEG_ACTIVE_LOW ? ~g : g;
  endfunction

  logic [LED_WIDTH-1:0]             led_q, led_d;
  logic [NUM_DIGITS-1:0]            mode_q, mode_d;
  logic [NUM_DIGITS:0]              blink_q, blink_d;
  logic [PWM_BITS-1:0]              bright_q, bright_d;
  logic [NUM_DIGITS-1:0][7:0]       digit_q, digit_d;
  logic [PRE_W-1:0]                 pre_q, pre_d;
  logic [PWM_BITS-1:0]              pwm_q, pwm_d;
  logic                             phase_q, phase_d;
  logic [31:0]                      rdata_q, rdata_d;
  logic [LED_WIDTH-1:0]             led_out_q, led_out_d;
  logic [NUM_DIGITS*8-1:0]          hex_out_q, hex_out_d;
  logic [31:0]                      rd_word;
  logic                             pwm_on;
  logic                             unused_wdata;

  assign unused_wdata = ^avs_writedata;

  always_comb begin
    led_d    = led_q;
    mode_d   = mode_q;
    blink_d  = blink_q;
    bright_d = bright_q;
    digit_d  = digit_q;
    if (avs_write) begin
      case (avs_address)
        4'd0:    led_d    = avs_writedata[LED_WIDTH-1:0];
        4'd1:    mode_d   = avs_writedata[NUM_DIGITS-1:0];
        4'd2:    blink_d  = avs_writedata[NUM_DIGITS:0];
        4'd3:    bright_d = avs_writedata[PWM_BITS-1:0];
        default: ;
      endcase
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (avs_address == 4'(i + 4)) digit_d[i] = avs_writedata[7:0];
      end
    end
  end

  // Read mux sees the registers before any same-cycle write lands
  always_comb begin
    rd_word = '0;
    case (avs_address)
      4'd0:    rd_word[LED_WIDTH-1:0]  = led_q;
      4'd1:    rd_word[NUM_DIGITS-1:0] = mode_q;
      4'd2:    rd_word[NUM_DIGITS:0]   = blink_q;
      4'd3:    rd_word[PWM_BITS-1:0]   = bright_q;
      default: ;
    endcase
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (avs_address == 4'(i + 4)) rd_word[7:0] = digit_q[i];
    end
    rdata_d = avs_read ? rd_word : rdata_q;
  end

  always_comb begin
    pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    phase_d = (pre_q == PRE_LAST) ? ~phase_q : phase_q;
    pwm_d   = pwm_q + 1'b1;
  end

  always_comb begin
    pwm_on    = (pwm_q <= bright_q);
    led_out_d = (pwm_on && !(blink_q[NUM_DIGITS] && phase_q)) ? led_q : '0;
    hex_out_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_out_d[8*i +: 8] = digit_pins(mode_q[i], digit_q[i], blink_q[i] && phase_q, pwm_on);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      led_q     <= '0;
      mode_q    <= '0;
      blink_q   <= '0;
      bright_q  <= '1;
      digit_q   <= '0;
      pre_q     <= '0;
      pwm_q     <= '0;
      phase_q   <= 1'b0;
      rdata_q   <= '0;
      led_out_q <= '0;
      hex_out_q <= HEX_BLANK;
    end else begin
      led_q     <= led_d;
      mode_q    <= mode_d;
      blink_q   <= blink_d;
      bright_q  <= bright_d;
      digit_q   <= digit_d;
      pre_q     <= pre_d;
      pwm_q     <= pwm_d;
      phase_q   <= phase_d;
      rdata_q   <= rdata_d;
      led_out_q <= led_out_d;
      hex_out_q <= hex_out_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign led_export   = led_out_q;
  assign hex_export   = hex_out_q;
  assign blink_phase  = phase_q;

endmodule
